ram_cmd_sequencer: RTL and testbench

Upstream command stage for the single-port RAM test block. It accepts write/read requests over a valid/ready handshake, buffers them in a small FIFO, and packs each one into the 32-bit command word the RAM stage decodes (bit 0 = write enable, bits 6:1 = address, remaining bits = payload). It also runs a 64-entry clear sweep on request. It emits a read tag pipeline so the downstream consumer can tell which RAM output word answers which read.

---
 rtl/ram_seq_pkg.sv | 18 +
 rtl/ram_seq_fifo.sv | 47 ++++
 rtl/ram_cmd_sequencer.sv | 146 ++++++++++++++
 tb/tb_ram_cmd_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_seq_pkg.sv
// Shared types and field layout for the RAM command sequencer.
package ram_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int ADDR_W      = 6;
  localparam int RAM_WORDS   = 64;

  // Command word layout: {payload, addr, we}
  localparam int WE_BIT      = 0;
  localparam int ADDR_LSB    = 1;
  localparam int PAYLOAD_LSB = 7;

endpackage

// File: rtl/ram_seq_fifo.sv
// Small synchronous request FIFO, falling-edge clocked, head visible combinationally.
module ram_seq_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [DW-1:0]    i_data,
  output logic [DW-1:0]    o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage is not reset; only the pointers decide what is valid.
  always_ff @(negedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/ram_cmd_sequencer.sv
// Request FIFO + issue/clear FSM that packs RAM command words and tracks read tags.
module ram_cmd_sequencer
  import ram_seq_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [WIDTH-8:0]  i_req_payload,
  input  logic              i_clr_start,
  output logic [WIDTH-1:0]  o_ram_word,
  output logic              o_rd_tag_valid,
  output logic [ADDR_W-1:0] o_rd_tag_addr,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_entry;
  logic [WIDTH-1:0] w_head;
  logic             w_sweep_last;
  logic             w_clear_nxt;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [WIDTH-1:0]  r_word;
  logic              r_rd;
  logic              r_ready_en;
  logic              r_busy;
  logic [RD_LAT-1:0]              r_tag_vld;
  logic [RD_LAT-1:0][ADDR_W-1:0]  r_tag_addr;

  // FIFO entries are stored already in command-word layout.
  assign w_entry = {i_req_payload, i_req_addr, i_req_we};

  // No push-through when full: ready only looks at the current occupancy.
  assign o_req_ready = r_ready_en && !w_full;
  assign w_push      = i_req_valid && o_req_ready;
  // A clear request outranks popping the head on the same edge.
  assign w_pop       = (r_state != CLEAR) && !i_clr_start && !w_empty;
  assign w_cnt_nxt   = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  assign w_sweep_last = (r_state == CLEAR) && (r_cnt == ADDR_W'(RAM_WORDS - 1));
  assign w_clear_nxt  = ((r_state != CLEAR) && i_clr_start) ||
                        ((r_state == CLEAR) && !w_sweep_last);

  ram_seq_fifo #(
    .DW    (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_entry),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Issue FSM: pops one request per edge, or runs the 64-word clear sweep.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      r_rd    <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_word <= {{(WIDTH - PAYLOAD_LSB){1'b0}}, r_cnt, 1'b1};
          r_rd   <= 1'b0;
          r_cnt  <= r_cnt + ADDR_W'(1);
          if (w_sweep_last)
            r_state <= (w_cnt_nxt != '0) ? ISSUE : IDLE;
        end
        IDLE, ISSUE: begin
          if (i_clr_start) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_word  <= '0;
            r_rd    <= 1'b0;
          end else if (!w_empty) begin
            r_word  <= w_head;
            r_rd    <= !w_head[WE_BIT];
            r_state <= (w_cnt_nxt == '0) ? IDLE : ISSUE;
          end else begin
            r_word  <= '0;
            r_rd    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_word  <= '0;
          r_rd    <= 1'b0;
        end
      endcase
    end
  end

  // Read tag shift register; stage 0 captures the word currently on the RAM port.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld  <= '0;
      r_tag_addr <= '0;
    end else begin
      r_tag_vld[0]  <= r_rd;
      r_tag_addr[0] <= r_rd ? r_word[ADDR_LSB +: ADDR_W] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_addr[i] <= r_tag_addr[i-1];
      end
    end
  end

  // Ready gate comes up one edge after reset; busy tracks pending sweep or queued work.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_ready_en <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      r_busy     <= w_clear_nxt || (w_cnt_nxt != '0);
    end
  end

  assign o_ram_word     = r_word;
  assign o_rd_tag_valid = r_tag_vld[RD_LAT-1];
  assign o_rd_tag_addr  = r_tag_addr[RD_LAT-1];
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_ram_cmd_sequencer.sv
// Directed bench for ram_cmd_sequencer; DUT state changes on the falling edge, bench samples at the rising edge.
module tb_ram_cmd_sequencer;

  logic        clk;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [5:0]  i_req_addr;
  logic [24:0] i_req_payload;
  logic        i_clr_start;
  logic [31:0] o_ram_word;
  logic        o_rd_tag_valid;
  logic [5:0]  o_rd_tag_addr;
  logic        o_busy;

  int n_chk;
  int n_err;

  ram_cmd_sequencer #(.WIDTH(32), .DEPTH(4), .RD_LAT(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_we       (i_req_we),
    .i_req_addr     (i_req_addr),
    .i_req_payload  (i_req_payload),
    .i_clr_start    (i_clr_start),
    .o_ram_word     (o_ram_word),
    .o_rd_tag_valid (o_rd_tag_valid),
    .o_rd_tag_addr  (o_rd_tag_addr),
    .o_busy         (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One active (falling) edge, then land on the following rising edge to sample.
  task automatic step();
    @(negedge clk);
    @(posedge clk);
  endtask

  function automatic logic [31:0] cmd(input logic we, input logic [5:0] a, input logic [24:0] p);
    return {p, a, we};
  endfunction

  task automatic push_in(input logic we, input logic [5:0] a, input logic [24:0] p);
    i_req_valid   = 1'b1;
    i_req_we      = we;
    i_req_addr    = a;
    i_req_payload = p;
  endtask

  task automatic quiet();
    i_req_valid   = 1'b0;
    i_req_we      = 1'b0;
    i_req_addr    = '0;
    i_req_payload = '0;
    i_clr_start   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    logic acc;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    quiet();
    repeat (2) step();

    // Reset state
    chk("rst_word",  o_ram_word, 32'h0);
    chk("rst_ready", o_req_ready, 1'b0);
    chk("rst_busy",  o_busy, 1'b0);
    chk("rst_tag",   o_rd_tag_valid, 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", o_req_ready, 1'b1);

    // Single write then read
    push_in(1'b1, 6'd5, 25'h1ABCDE);
    step();
    chk("wr_accept_word", o_ram_word, 32'h0);
    chk("wr_busy", o_busy, 1'b1);
    push_in(1'b0, 6'd5, 25'h0);
    step();
    chk("wr_word", o_ram_word, 32'h0D5E6F0B);
    quiet();
    step();
    chk("rd_word", o_ram_word, 32'h0000000A);
    chk("rd_tag_e3", o_rd_tag_valid, 1'b0);
    step();
    chk("idle_after_rd", o_ram_word, 32'h0);
    chk("rd_tag_e4", o_rd_tag_valid, 1'b0);
    step();
    chk("rd_tag_e5", o_rd_tag_valid, 1'b1);
    chk("rd_tag_addr", o_rd_tag_addr, 6'd5);
    step();
    chk("rd_tag_e6", o_rd_tag_valid, 1'b0);

    // Clear sweep with an ignored second clr_start
    i_clr_start = 1'b1;
    step();
    i_clr_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      i_clr_start = (i == 10);
      step();
      i_clr_start = 1'b0;
      chk($sformatf("sweep_w%0d", i), o_ram_word, (i << 1) | 1);
      if (i < 63) chk($sformatf("sweep_busy%0d", i), o_busy, 1'b1);
    end
    step();
    chk("sweep_end_word", o_ram_word, 32'h0);
    chk("sweep_end_busy", o_busy, 1'b0);

    // Backpressure: 6 offered reads during a sweep, only 4 fit
    i_clr_start = 1'b1;
    step();
    i_clr_start = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      push_in(1'b0, 6'(10 + n_acc), 25'h0);
      acc = o_req_ready;
      step();
      if (acc) n_acc++;
    end
    chk("bp_accepts", n_acc, 4);
    chk("bp_ready_low", o_req_ready, 1'b0);
    quiet();
    repeat (58) step();
    chk("bp_last_sweep", o_ram_word, 32'h7F);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("bp_word%0d", k), o_ram_word, (k < 4) ? ((10 + k) << 1) : 0);
      chk($sformatf("bp_tagv%0d", k), o_rd_tag_valid, (k >= 2));
      if (k >= 2) chk($sformatf("bp_taga%0d", k), o_rd_tag_addr, 10 + k - 2);
      if (k == 0) begin
        chk("bp_busy_drain", o_busy, 1'b1);
        chk("bp_ready_back", o_req_ready, 1'b1);
      end
      if (k == 3) chk("bp_busy_done", o_busy, 1'b0);
    end

    // Clear vs pop collision: 2 entries queued in ISSUE when clr_start arrives
    i_clr_start = 1'b1;
    step();
    i_clr_start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      push_in(1'b1, 6'(20 + j), 25'(32'h100 + j));
      step();
    end
    quiet();
    repeat (61) step();
    step();
    chk("col_first", o_ram_word, cmd(1'b1, 6'd20, 25'h100));
    i_clr_start = 1'b1;
    step();
    i_clr_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      chk($sformatf("col_sweep%0d", i), o_ram_word, (i << 1) | 1);
    end
    step();
    chk("col_e65", o_ram_word, cmd(1'b1, 6'd21, 25'h101));
    step();
    chk("col_e66", o_ram_word, cmd(1'b1, 6'd22, 25'h102));
    step();
    chk("col_idle", o_ram_word, 32'h0);

    // Reset in mid-sweep with 3 queued reads
    i_clr_start = 1'b1;
    step();
    i_clr_start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      push_in(1'b0, 6'(30 + j), 25'h0);
      step();
    end
    quiet();
    repeat (18) step();
    chk("mid_addr20", o_ram_word, 32'h29);
    #2 rst = 1'b1;
    #1;
    chk("async_word",  o_ram_word, 32'h0);
    chk("async_ready", o_req_ready, 1'b0);
    chk("async_busy",  o_busy, 1'b0);
    chk("async_tagv",  o_rd_tag_valid, 1'b0);
    chk("async_taga",  o_rd_tag_addr, 6'd0);
    step();
    rst = 1'b0;
    chk("rel_ready_pre", o_req_ready, 1'b0);
    step();
    chk("rel_ready", o_req_ready, 1'b1);
    chk("rel_busy",  o_busy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rel_word%0d", i), o_ram_word, 32'h0);
      chk($sformatf("rel_tag%0d", i), o_rd_tag_valid, 1'b0);
    end

    // Idle behaviour
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("idle_word%0d", i), o_ram_word, 32'h0);
      chk($sformatf("idle_tag%0d", i), o_rd_tag_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
